// File: rtl/instr_encoder.sv
// instr_encoder: builds MIPS instruction words from decoded fields and streams
// them into instruction memory at consecutive word addresses.
// Input side: valid/ready into a small FIFO of already-encoded words.
// Output side: imem write port with backpressure (imem_ready).
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              mem_full,
  output logic              err,
  input  logic              err_clr,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [CNT_W-1:0]  FIFO_CAP = CNT_W'(FIFO_DEPTH);

  // Instruction classes, matching the main control decoder's view of the ISA.
  localparam logic [2:0] KIND_R    = 3'd0;
  localparam logic [2:0] KIND_LW   = 3'd1;
  localparam logic [2:0] KIND_SW   = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_ADDI = 3'd4;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [31:0]       fifo_mem_q [FIFO_DEPTH];

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic              err_q, err_d;

  logic [31:0]       enc_word;
  logic              kind_legal;
  logic              fifo_empty;
  logic              fifo_full;
  logic              in_xfer;
  logic              enq;
  logic              illegal_xfer;
  logic              deq;

  // Encode the incoming field bundle; unused fields of each class are ignored.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, otherwise synthesis infers a latch.
  always_comb begin
    enc_word   = '0;
    kind_legal = 1'b1;
    case (in_kind)
      KIND_R:    enc_word = {OP_R, in_rs, in_rt, in_rd, 5'd0, in_funct};
      KIND_LW:   enc_word = {OP_LW, in_rs, in_rt, in_imm};
      KIND_SW:   enc_word = {OP_SW, in_rs, in_rt, in_imm};
      KIND_BEQ:  enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
      KIND_ADDI: enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
      default:   kind_legal = 1'b0;
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_CAP);

  // Transfer qualifiers; start discards both the input bundle and the write.
  always_comb begin
    in_xfer      = in_valid && in_ready && !start;
    enq          = in_xfer && kind_legal;
    illegal_xfer = in_xfer && !kind_legal;
    deq          = imem_we && imem_ready && !start;
  end

  // FSM state register.
  // NOTE: clocked blocks use non-blocking assignments so every flop samples
  // its pre-edge inputs; blocking here would create simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: RUN stops at the last address; only start re-arms it.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (deq && (addr_q == LAST)) state_d = ST_FULL;
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM outputs: derived only from registered state, never from imem_ready.
  always_comb begin
    in_ready   = (state_q == ST_RUN) && !fifo_full;
    imem_we    = (state_q == ST_RUN) && !fifo_empty;
    mem_full   = (state_q == ST_FULL);
    imem_wdata = imem_we ? fifo_mem_q[rd_ptr_q] : 32'd0;
  end

  // FIFO pointer and occupancy update; enqueue plus dequeue keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; written on enqueue only.
  // NOTE: the storage array has no reset; emptiness is tracked by count_q and
  // the output is gated by imem_we, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem_q[wr_ptr_q] <= enc_word;
  end

  // Write address, written-word count and sticky error next values.
  always_comb begin
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    if (start) begin
      addr_d     = BASE;
      word_cnt_d = '0;
    end else if (deq) begin
      word_cnt_d = word_cnt_q + WCNT_W'(1);
      if (addr_q != LAST) addr_d = addr_q + ADDR_W'(1);
    end
    err_d = err_q;
    if (err_clr)      err_d = 1'b0;
    if (illegal_xfer) err_d = 1'b1;
  end

  // Address, count and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= BASE;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  assign imem_addr = addr_q;
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed instruction words.
// dut_a uses ADDR_W=8 for encoding/backpressure/error/reset scenarios;
// dut_b uses ADDR_W=2 to reach the end of memory quickly.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        err_clr;
  logic        imem_ready;
  logic        valid;
  logic        sel_b;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;

  logic        valid_a, valid_b;
  logic        in_ready_a, imem_we_a, mem_full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;
  logic        in_ready_b, imem_we_b, mem_full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  log_addr_a[$];
  logic [31:0] log_data_a[$];
  logic [1:0]  log_addr_b[$];
  logic [31:0] log_data_b[$];

  assign valid_a = valid && !sel_b;
  assign valid_b = valid && sel_b;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(valid_a), .in_ready(in_ready_a),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm),
    .imem_we(imem_we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .imem_ready(imem_ready), .mem_full(mem_full_a), .err(err_a),
    .err_clr(err_clr), .word_cnt(cnt_a)
  );

  instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(valid_b), .in_ready(in_ready_b),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm),
    .imem_we(imem_we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .imem_ready(imem_ready), .mem_full(mem_full_b), .err(err_b),
    .err_clr(err_clr), .word_cnt(cnt_b)
  );

  // Write monitor: samples mid-low-phase the write that completes at the next edge.
  always @(negedge clk) begin
    #2;
    if (!rst && !start) begin
      if (imem_we_a && imem_ready) begin
        log_addr_a.push_back(addr_a);
        log_data_a.push_back(wdata_a);
      end
      if (imem_we_b && imem_ready) begin
        log_addr_b.push_back(addr_b);
        log_data_b.push_back(wdata_b);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [5:0] f, input logic [15:0] i);
    in_kind  = k;
    in_rs    = s;
    in_rt    = t;
    in_rd    = d;
    in_funct = f;
    in_imm   = i;
  endtask

  // Waits (bounded) for in_ready of the selected DUT, then completes the transfer.
  task automatic wait_accept(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (sel_b ? in_ready_b : in_ready_a) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic push(input string tag, input logic [2:0] k, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [5:0] f,
                      input logic [15:0] i);
    set_fields(k, s, t, d, f, i);
    valid = 1'b1;
    wait_accept(tag);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    log_addr_a.delete();
    log_data_a.delete();
    log_addr_b.delete();
    log_data_b.delete();
  endtask

  logic [31:0] exp_enc [5];
  logic [31:0] exp_bp  [5];
  logic [31:0] exp_full[4];

  initial begin
    rst = 1'b1; start = 1'b0; err_clr = 1'b0; imem_ready = 1'b1;
    valid = 1'b0; sel_b = 1'b0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);

    // ---------------- reset state ----------------
    #12;
    check("rst_we",    64'(imem_we_a), 64'd0);
    check("rst_wdata", 64'(wdata_a),   64'd0);
    check("rst_addr",  64'(addr_a),    64'd0);
    check("rst_full",  64'(mem_full_a), 64'd0);
    check("rst_err",   64'(err_a),     64'd0);
    check("rst_cnt",   64'(cnt_a),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready_a), 64'd1);

    // ---------------- encoding ----------------
    exp_enc[0] = 32'h8D090004;
    exp_enc[1] = 32'h00221820;
    exp_enc[2] = 32'hAD090008;
    exp_enc[3] = 32'h1022FFFF;
    exp_enc[4] = 32'h20010005;
    push("acc_lw", 3'd1, 5'd8, 5'd9, 5'd31, 6'h3F, 16'h0004);
    check("lat_we",    64'(imem_we_a), 64'd1);
    check("lat_wdata", 64'(wdata_a),   64'(exp_enc[0]));
    check("lat_addr",  64'(addr_a),    64'd0);
    push("acc_add",  3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF);
    push("acc_sw",   3'd2, 5'd8, 5'd9, 5'd0, 6'd0,  16'h0008);
    push("acc_beq",  3'd3, 5'd1, 5'd2, 5'd0, 6'd0,  16'hFFFF);
    push("acc_addi", 3'd4, 5'd0, 5'd1, 5'd7, 6'h11, 16'h0005);
    repeat (4) @(negedge clk);
    check("enc_nwrites", 64'(log_data_a.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_data_a.size()) begin
        check($sformatf("enc_addr%0d", i), 64'(log_addr_a[i]), 64'(i));
        check($sformatf("enc_data%0d", i), 64'(log_data_a[i]), 64'(exp_enc[i]));
      end
    end
    check("enc_cnt",   64'(cnt_a),  64'd5);
    check("enc_addr",  64'(addr_a), 64'd5);
    check("enc_we",    64'(imem_we_a), 64'd0);

    // ---------------- backpressure ----------------
    start_pulse();
    check("start_addr", 64'(addr_a), 64'd0);
    check("start_cnt",  64'(cnt_a),  64'd0);
    imem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_bp[k-1] = {6'd8, 5'd0, 5'(k), 16'(k)};
      push($sformatf("bp_acc%0d", k), 3'd4, 5'd0, 5'(k), 5'd0, 6'd0, 16'(k));
    end
    exp_bp[4] = 32'hAC050010;
    check("bp_ready_low", 64'(in_ready_a), 64'd0);
    set_fields(3'd2, 5'd0, 5'd5, 5'd0, 6'd0, 16'h0010);
    valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bp_stall_ready", 64'(in_ready_a), 64'd0);
      check("bp_stall_we",    64'(imem_we_a),  64'd1);
      check("bp_stall_data",  64'(wdata_a),    64'(exp_bp[0]));
      check("bp_stall_addr",  64'(addr_a),     64'd0);
    end
    imem_ready = 1'b1;
    wait_accept("bp_acc5");
    repeat (6) @(negedge clk);
    check("bp_nwrites", 64'(log_data_a.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_data_a.size()) begin
        check($sformatf("bp_addr%0d", i), 64'(log_addr_a[i]), 64'(i));
        check($sformatf("bp_data%0d", i), 64'(log_data_a[i]), 64'(exp_bp[i]));
      end
    end
    check("bp_cnt", 64'(cnt_a), 64'd5);

    // ---------------- illegal kind ----------------
    start_pulse();
    push("ill_acc", 3'd6, 5'd1, 5'd2, 5'd3, 6'd4, 16'h1234);
    check("ill_err", 64'(err_a),     64'd1);
    check("ill_we",  64'(imem_we_a), 64'd0);
    push("ill_legal", 3'd4, 5'd2, 5'd3, 5'd0, 6'd0, 16'h00AA);
    repeat (3) @(negedge clk);
    check("ill_nwrites", 64'(log_data_a.size()), 64'd1);
    if (log_data_a.size() > 0) begin
      check("ill_wr_addr", 64'(log_addr_a[0]), 64'd0);
      check("ill_wr_data", 64'(log_data_a[0]), 64'h204300AA);
    end
    check("ill_err_sticky", 64'(err_a), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ill_err_clr", 64'(err_a), 64'd0);
    err_clr = 1'b1;
    push("ill_acc7", 3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
    err_clr = 1'b0;
    check("ill_set_wins", 64'(err_a), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ill_err_clr2", 64'(err_a), 64'd0);

    // ---------------- memory full (ADDR_W=2) ----------------
    sel_b = 1'b1;
    start_pulse();
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 4) exp_full[k] = {6'd8, 5'd0, 5'(k), 16'(16'h0100 + k)};
      push($sformatf("full_acc%0d", k), 3'd4, 5'd0, 5'(k), 5'd0, 6'd0, 16'(16'h0100 + k));
    end
    check("full_fifo_ready", 64'(in_ready_b), 64'd0);
    imem_ready = 1'b1;
    for (int k = 4; k < 6; k++) begin
      push($sformatf("full_acc%0d", k), 3'd4, 5'd0, 5'(k), 5'd0, 6'd0, 16'(16'h0100 + k));
    end
    repeat (6) @(negedge clk);
    check("full_nwrites", 64'(log_data_b.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_data_b.size()) begin
        check($sformatf("full_addr%0d", i), 64'(log_addr_b[i]), 64'(i));
        check($sformatf("full_data%0d", i), 64'(log_data_b[i]), 64'(exp_full[i]));
      end
    end
    check("full_flag",  64'(mem_full_b), 64'd1);
    check("full_ready", 64'(in_ready_b), 64'd0);
    check("full_we",    64'(imem_we_b),  64'd0);
    check("full_addr",  64'(addr_b),     64'd3);
    check("full_cnt",   64'(cnt_b),      64'd4);
    start_pulse();
    check("rearm_flag",  64'(mem_full_b), 64'd0);
    check("rearm_addr",  64'(addr_b),     64'd0);
    check("rearm_cnt",   64'(cnt_b),      64'd0);
    check("rearm_we",    64'(imem_we_b),  64'd0);
    check("rearm_ready", 64'(in_ready_b), 64'd1);
    repeat (3) @(negedge clk);
    check("rearm_nwrites", 64'(log_data_b.size()), 64'd0);
    sel_b = 1'b0;

    // ---------------- async reset mid-stream ----------------
    imem_ready = 1'b1;
    push("ar_acc0", 3'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0040);
    @(negedge clk);
    imem_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("ar_acc%0d", k), 3'd4, 5'd0, 5'(k), 5'd0, 6'd0, 16'(k));
    end
    check("ar_pre_we",  64'(imem_we_a), 64'd1);
    check("ar_pre_cnt", 64'(cnt_a),     64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_we",    64'(imem_we_a), 64'd0);
    check("ar_addr",  64'(addr_a),    64'd0);
    check("ar_cnt",   64'(cnt_a),     64'd0);
    check("ar_wdata", 64'(wdata_a),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
    log_addr_a.delete();
    log_data_a.delete();
    repeat (6) @(negedge clk);
    check("ar_nwrites", 64'(log_data_a.size()), 64'd0);
    check("ar_post_we", 64'(imem_we_a), 64'd0);
    check("ar_ready",   64'(in_ready_a), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembles MIPS instruction words from decoded fields and streams them into instruction memory at consecutive word addresses.
- It is the inverse of the main control decoder. It encodes the same five instruction classes (R-type, lw, sw, beq, addi) into the opcodes that decoder consumes.
- Used by the program loader and testbenches to fill imem before the CPU runs.
- Input side is a valid/ready handshake into a small FIFO. Output side is a write port with backpressure.

Parameters:
- ADDR_W, 8, imem word-address width.
- FIFO_DEPTH, 4, encoded-word FIFO entries; power of two, ≥2.
- BASE_ADDR, 0, first word address written after reset or start.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: FIFO flush, address reload to BASE_ADDR, state to RUN.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- in_kind  input  3  0=R, 1=lw, 2=sw, 3=beq, 4=addi; 5-7 illegal.
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field; used for R only.
- in_funct  input  6  funct field; used for R only.
- in_imm  input  16  immediate/offset; used for I-types only.
- imem_we  output  1  write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- imem_ready  input  1  memory accepts the write this cycle.
- mem_full  output  1  last address written; no further writes.
- err  output  1  sticky: illegal kind seen.
- err_clr  input  1  clears err.
- word_cnt  output  ADDR_W+1  words written since reset/start.

Behaviour:
- Reset (async, rst=1):
  - State RUN, FIFO empty, imem_addr=BASE_ADDR.
  - imem_we=0, imem_wdata=0, mem_full=0, err=0, word_cnt=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-write drops all pending FIFO words.
- Encoding is combinational at the input and stored encoded in the FIFO:
  - R: {6'd0, rs, rt, rd, 5'd0, funct}.
  - lw: {6'd35, rs, rt, imm}.
  - sw: {6'd43, rs, rt, imm}.
  - beq: {6'd4, rs, rt, imm}.
  - addi: {6'd8, rs, rt, imm}.
  - Unused fields are ignored (e.g. rd for I-types, imm for R).
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = !fifo_full && state==RUN, registered-state only; no combinational path from imem_ready.
  - No enqueue bypass: a full FIFO with simultaneous dequeue still shows in_ready=0 that cycle.
- Illegal kind (5-7):
  - The handshake completes, nothing is enqueued, and err sets the next cycle.
  - err_clr and a simultaneous illegal transfer: set wins.
- Write side:
  - imem_we = FIFO non-empty && state==RUN; imem_wdata = FIFO head.
  - A write completes on imem_we && imem_ready. Then: dequeue, imem_addr+1, word_cnt+1.
  - imem_ready=0 holds addr, data and we stable.
- Latency: a bundle accepted at edge N is presented on imem_* from cycle N+1. Back-to-back accepts and writes sustain 1 word/cycle.
- FSM:
  - RUN -> FULL when a write completes at address 2^ADDR_W-1. mem_full=1, imem_we=0, in_ready=0; the address does not wrap.
  - FULL -> RUN only on start or rst.
  - start in any state: FIFO flushed, imem_addr=BASE_ADDR, word_cnt=0, mem_full=0, err unchanged.
  - start has priority over a same-cycle handshake or write; that input bundle and that write are discarded.
- FIFO: circular with a count register. Simultaneous enqueue and dequeue keeps the count.

Test Plan:
- Encoding:
  - lw rs=8 rt=9 imm=4 -> 0x8D090004 @ addr 0.
  - add R rs=1 rt=2 rd=3 funct=0x20 -> 0x00221820 @ addr 1.
  - sw rs=8 rt=9 imm=8 -> 0xAD090008.
  - beq rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
  - addi rs=0 rt=1 imm=5 -> 0x20010005.
  - word_cnt=5 after all five.
- Backpressure: imem_ready=0, push 5 valid bundles -> in_ready drops after 4. Raise imem_ready -> 5 writes at addrs 0-4 in order, data unchanged while stalled.
- Illegal: in_kind=6 -> no write, err=1 stays set across later legal writes. err_clr pulse -> err=0.
- Full: ADDR_W=2, push 6 words -> writes at addrs 0-3 only, mem_full=1, in_ready=0, remaining words stay in the FIFO unwritten. start -> mem_full=0, addr=0, FIFO empty.
- Async reset mid-stream: assert rst between clock edges with 3 words queued -> imem_we=0 immediately, addr=BASE_ADDR, word_cnt=0, no stale writes after release.
